branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Carries each fetched instruction's branch prediction through IF/ID, ID/EX and EX/MEM.
- Compares the prediction with the outcome resolved in EX.
- From MEM, drives the training inputs of the 2-bit BHT predictor and the fetch redirect/flush on a mispredict.
- No branch delay slot.

Parameters:
CNT_WIDTH, 32, width of the branch and mispredict performance counters (wrap modulo 2^CNT_WIDTH)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
i_stall  input  1  pipeline stall; all stage registers hold
i_IF_valid  input  1  IF holds a real instruction
i_IF_pc  input  32  PC of fetched instruction
i_IF_pred_taken  input  1  predictor taken bit for i_IF_pc
i_IF_pred_next_pc  input  32  predicted next PC used by fetch
i_EX_is_branch  input  1  EX instruction is a conditional branch
i_EX_is_jump  input  1  EX instruction is an unconditional jump (imm or reg)
i_EX_cond_true  input  1  branch condition evaluated true
i_EX_target_pc  input  32  resolved branch/jump target
o_MEM_branch_pc  output  32  PC of conditional branch in MEM (predictor update index)
o_MEM_is_branch_instr  output  1  one-cycle predictor update strobe
o_MEM_is_take_branch  output  1  actual direction for update
o_redirect  output  1  one-cycle fetch redirect pulse
o_redirect_pc  output  32  correct next PC
o_flush  output  1  equals o_redirect; younger pipeline stages squash
o_branch_cnt  output  CNT_WIDTH  conditional branches retired to MEM
o_mispred_cnt  output  CNT_WIDTH  redirects issued

Behaviour:
- Reset (async, resetn low): all stage valid bits 0; all outputs 0, including PCs and counters. Release is synchronous to clk.
- Stage regs IFID, IDEX: each holds {valid, pc, pred_taken, pred_next_pc}. EXMEM holds {valid, pc, is_branch, taken, mispred, actual_next}.
- Advance (i_stall=0, o_flush=0):
  - IFID <= IF inputs.
  - IDEX <= IFID.
  - EXMEM <= IDEX plus EX resolution.
- EX resolution (combinational on IDEX):
  - taken = i_EX_is_jump | (i_EX_is_branch & i_EX_cond_true).
  - actual_next = taken ? i_EX_target_pc : pc+4, 32-bit wrap.
  - mispred = IDEX.valid & (actual_next != IDEX.pred_next_pc).
  - The comparison is against the predicted PC, not pred_taken alone. A taken prediction with a wrong target is a mispredict.
- i_stall=1: IFID, IDEX and EXMEM hold.
- Strobes: o_MEM_is_branch_instr and o_redirect are registered pulses. They are set only in the cycle an entry is loaded into EXMEM and cleared the next cycle even if stall holds EXMEM. Each instruction trains and redirects at most once.
  - o_MEM_is_branch_instr = loaded valid & is_branch. Jumps never train.
  - o_MEM_is_take_branch and o_MEM_branch_pc are registered alongside and held until the next load.
  - o_redirect = loaded valid & mispred. o_redirect_pc = actual_next, held until the next load.
- Flush: when o_redirect=1, at the next edge IFID.valid and IDEX.valid <= 0 and EXMEM loads a bubble (valid 0). This applies regardless of i_stall, so flush has priority. The IF inputs are discarded that edge.
- Latency: fetch at cycle t, no stall → update/redirect strobe visible during cycle t+3.
- Counters:
  - o_branch_cnt increments with each o_MEM_is_branch_instr pulse.
  - o_mispred_cnt increments with each o_redirect pulse.
  - Both wrap at 2^CNT_WIDTH and are not cleared by flush.
- Invalid entries (valid 0) never produce strobes or counter increments, whatever the EX inputs.
- Reset asserted mid-operation clears everything immediately. No strobe may appear in the cycle after release.

Test Plan:
- Branch at pc 0x100, not-taken prediction (pred_next 0x104), cond_true, target 0x200 → 3 cycles later: update strobe with pc 0x100, take=1; redirect=1, redirect_pc 0x200; both valid bits cleared next edge; mispred_cnt 1.
- Branch at 0x40 predicted taken to 0x80, actual taken to 0x80 → update strobe take=1, no redirect, branch_cnt 1, mispred_cnt 0.
- Jump at 0x10, pred_next 0x14, target 0x300 → redirect to 0x300, no update strobe, branch_cnt 0.
- Mispredicting branch enters MEM while i_stall=1 for 4 cycles → strobes exactly 1 cycle, o_MEM_branch_pc stays 0x100, counters +1 only.
- Two back-to-back branches, first mispredicts → second squashed: no strobe for it; next strobe comes from the first correct-path instruction.
- resetn low during a pending redirect → all outputs 0 asynchronously; after release, no strobe until a new fetch reaches MEM; set CNT_WIDTH=4 and retire 16 branches → o_branch_cnt wraps to 0.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: carries predictions to MEM, resolves them in EX, drives predictor training and fetch redirect
module branch_resolve #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_stall,
    input  logic                 i_IF_valid,
    input  logic [31:0]          i_IF_pc,
    input  logic                 i_IF_pred_taken,
    input  logic [31:0]          i_IF_pred_next_pc,
    input  logic                 i_EX_is_branch,
    input  logic                 i_EX_is_jump,
    input  logic                 i_EX_cond_true,
    input  logic [31:0]          i_EX_target_pc,
    output logic [31:0]          o_MEM_branch_pc,
    output logic                 o_MEM_is_branch_instr,
    output logic                 o_MEM_is_take_branch,
    output logic                 o_redirect,
    output logic [31:0]          o_redirect_pc,
    output logic                 o_flush,
    output logic [CNT_WIDTH-1:0] o_branch_cnt,
    output logic [CNT_WIDTH-1:0] o_mispred_cnt
);
    logic        ifid_valid, ifid_pred_taken, idex_valid, idex_pred_taken;
    logic [31:0] ifid_pc, ifid_pred_next_pc, idex_pc, idex_pred_next_pc;
    logic        ex_valid, ex_fresh, ex_is_branch, ex_taken, ex_mispred;
    logic [31:0] ex_pc, ex_actual_next;
    logic        res_taken, res_mispred;
    logic [31:0] res_next;
    logic        unused_pred_taken;
    always_comb begin
        res_taken   = i_EX_is_jump | (i_EX_is_branch & i_EX_cond_true);
        res_next    = res_taken ? i_EX_target_pc : idex_pc + 32'd4;
        res_mispred = idex_valid & (res_next != idex_pred_next_pc);
    end
    // direction is implied by pred_next_pc; the bit travels along for visibility only
    assign unused_pred_taken = idex_pred_taken;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ifid_valid        <= 1'b0;
            ifid_pc           <= '0;
            ifid_pred_taken   <= 1'b0;
            ifid_pred_next_pc <= '0;
            idex_valid        <= 1'b0;
            idex_pc           <= '0;
            idex_pred_taken   <= 1'b0;
            idex_pred_next_pc <= '0;
            ex_valid          <= 1'b0;
            ex_fresh          <= 1'b0;
            ex_is_branch      <= 1'b0;
            ex_taken          <= 1'b0;
            ex_mispred        <= 1'b0;
            ex_pc             <= '0;
            ex_actual_next    <= '0;
        end else if (o_redirect) begin
            ifid_valid <= 1'b0;
            idex_valid <= 1'b0;
            ex_valid   <= 1'b0;
            ex_fresh   <= 1'b0;
        end else if (!i_stall) begin
            ifid_valid        <= i_IF_valid;
            ifid_pc           <= i_IF_pc;
            ifid_pred_taken   <= i_IF_pred_taken;
            ifid_pred_next_pc <= i_IF_pred_next_pc;
            idex_valid        <= ifid_valid;
            idex_pc           <= ifid_pc;
            idex_pred_taken   <= ifid_pred_taken;
            idex_pred_next_pc <= ifid_pred_next_pc;
            ex_valid          <= idex_valid;
            ex_fresh          <= 1'b1;
            if (idex_valid) begin
                ex_is_branch   <= i_EX_is_branch;
                ex_taken       <= res_taken;
                ex_mispred     <= res_mispred;
                ex_pc          <= idex_pc;
                ex_actual_next <= res_next;
            end
        end else begin
            ex_fresh <= 1'b0;
        end
    end
    assign o_MEM_branch_pc       = ex_pc;
    assign o_MEM_is_branch_instr = ex_fresh & ex_valid & ex_is_branch;
    assign o_MEM_is_take_branch  = ex_taken;
    assign o_redirect            = ex_fresh & ex_valid & ex_mispred;
    assign o_redirect_pc         = ex_actual_next;
    assign o_flush               = o_redirect;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (o_MEM_is_branch_instr) o_branch_cnt <= o_branch_cnt + CNT_WIDTH'(1);
            if (o_redirect) o_mispred_cnt <= o_mispred_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed stimulus against an instruction-level model of branch resolution
module tb_branch_resolve;
    logic clk = 0, resetn = 1, i_stall = 0, i_IF_valid = 0, i_IF_pred_taken = 0;
    logic i_EX_is_branch = 0, i_EX_is_jump = 0, i_EX_cond_true = 0;
    logic [31:0] i_IF_pc = 0, i_IF_pred_next_pc = 0, i_EX_target_pc = 0;
    logic [31:0] o_MEM_branch_pc, o_redirect_pc, b4_branch_pc, b4_redirect_pc;
    logic o_MEM_is_branch_instr, o_MEM_is_take_branch, o_redirect, o_flush;
    logic b4_is_branch_instr, b4_is_take_branch, b4_redirect, b4_flush;
    logic [31:0] o_branch_cnt, o_mispred_cnt;
    logic [3:0] b4_branch_cnt, b4_mispred_cnt;

    branch_resolve dut (
        .clk(clk), .resetn(resetn), .i_stall(i_stall), .i_IF_valid(i_IF_valid), .i_IF_pc(i_IF_pc),
        .i_IF_pred_taken(i_IF_pred_taken), .i_IF_pred_next_pc(i_IF_pred_next_pc),
        .i_EX_is_branch(i_EX_is_branch), .i_EX_is_jump(i_EX_is_jump), .i_EX_cond_true(i_EX_cond_true),
        .i_EX_target_pc(i_EX_target_pc), .o_MEM_branch_pc(o_MEM_branch_pc),
        .o_MEM_is_branch_instr(o_MEM_is_branch_instr), .o_MEM_is_take_branch(o_MEM_is_take_branch),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
        .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    branch_resolve #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .i_stall(i_stall), .i_IF_valid(i_IF_valid), .i_IF_pc(i_IF_pc),
        .i_IF_pred_taken(i_IF_pred_taken), .i_IF_pred_next_pc(i_IF_pred_next_pc),
        .i_EX_is_branch(i_EX_is_branch), .i_EX_is_jump(i_EX_is_jump), .i_EX_cond_true(i_EX_cond_true),
        .i_EX_target_pc(i_EX_target_pc), .o_MEM_branch_pc(b4_branch_pc),
        .o_MEM_is_branch_instr(b4_is_branch_instr), .o_MEM_is_take_branch(b4_is_take_branch),
        .o_redirect(b4_redirect), .o_redirect_pc(b4_redirect_pc), .o_flush(b4_flush),
        .o_branch_cnt(b4_branch_cnt), .o_mispred_cnt(b4_mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pn;
        logic        br;
        logic        jmp;
        logic        cond;
        logic [31:0] tgt;
    } ins_t;

    localparam ins_t BUB = {1'b0, 32'hdead_beef, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0bad_0000};

    int checks = 0, failures = 0, cb = 0, cm = 0;
    bit run = 0;
    ins_t p0, p1;
    logic m_v, m_fresh, m_br, m_take, m_mis;
    logic [31:0] m_pc, m_next;

    function automatic ins_t mk(input logic [31:0] pc, input logic [31:0] pn, input logic br,
                                input logic jmp, input logic cond, input logic [31:0] tgt);
        mk = {1'b1, pc, pn, br, jmp, cond, tgt};
    endfunction

    function automatic ins_t nop(input logic [31:0] pc);
        nop = mk(pc, pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        p0 = BUB; p1 = BUB;
        m_v = 0; m_fresh = 0; m_br = 0; m_take = 0; m_mis = 0; m_pc = 0; m_next = 0;
        cb = 0; cm = 0;
    endtask

    // one clock edge of the instruction-level model: an instruction reaching MEM is resolved there
    task automatic model_edge(input ins_t f, input logic st);
        logic s, r, t;
        logic [31:0] n;
        s = m_fresh & m_v & m_br;
        r = m_fresh & m_v & m_mis;
        if (s) cb++;
        if (r) cm++;
        if (r) begin
            p0.v = 0; p1.v = 0; m_v = 0; m_fresh = 0;
        end else if (!st) begin
            t = p1.jmp | (p1.br & p1.cond);
            n = t ? p1.tgt : p1.pc + 32'd4;
            m_v = p1.v;
            m_fresh = 1;
            if (p1.v) begin
                m_br = p1.br; m_take = t; m_mis = (n != p1.pn); m_pc = p1.pc; m_next = n;
            end
            p1 = p0;
            p0 = f;
        end else begin
            m_fresh = 0;
        end
    endtask

    task automatic check_all();
        logic s, r;
        s = m_fresh & m_v & m_br;
        r = m_fresh & m_v & m_mis;
        chk("strobe", o_MEM_is_branch_instr, s);
        chk("take", o_MEM_is_take_branch, m_take);
        chk("branch_pc", o_MEM_branch_pc, m_pc);
        chk("redirect", o_redirect, r);
        chk("flush", o_flush, r);
        chk("redirect_pc", o_redirect_pc, m_next);
        chk("branch_cnt", o_branch_cnt, cb);
        chk("mispred_cnt", o_mispred_cnt, cm);
        chk("branch_cnt4", b4_branch_cnt, cb % 16);
        chk("mispred_cnt4", b4_mispred_cnt, cm % 16);
    endtask

    always @(negedge clk) if (run && resetn) check_all();

    task automatic step(input ins_t f, input logic st);
        i_stall = st;
        i_IF_valid = f.v;
        i_IF_pc = f.pc;
        i_IF_pred_next_pc = f.pn;
        i_IF_pred_taken = (f.pn != f.pc + 32'd4);
        i_EX_is_branch = p1.br;
        i_EX_is_jump = p1.jmp;
        i_EX_cond_true = p1.cond;
        i_EX_target_pc = p1.tgt;
        @(posedge clk);
        if (resetn) model_edge(f, st);
        @(negedge clk);
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, " branch_pc"}, o_MEM_branch_pc, 0);
        chk({nm, " strobe"}, o_MEM_is_branch_instr, 0);
        chk({nm, " take"}, o_MEM_is_take_branch, 0);
        chk({nm, " redirect"}, o_redirect, 0);
        chk({nm, " redirect_pc"}, o_redirect_pc, 0);
        chk({nm, " flush"}, o_flush, 0);
        chk({nm, " branch_cnt"}, o_branch_cnt, 0);
        chk({nm, " mispred_cnt"}, o_mispred_cnt, 0);
    endtask

    task automatic do_reset(input string nm);
        #1 resetn = 0;
        #1 zero_chk(nm);
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        model_reset();
        do_reset("rst0");
        run = 1;
        step(BUB, 0);
        chk("release quiet", {o_MEM_is_branch_instr, o_redirect}, 0);

        // mispredicted not-taken branch
        step(mk(32'h100, 32'h104, 1, 0, 1, 32'h200), 0);
        step(nop(32'h104), 0);
        step(nop(32'h108), 0);
        chk("t1 strobe", o_MEM_is_branch_instr, 1);
        chk("t1 branch_pc", o_MEM_branch_pc, 32'h100);
        chk("t1 take", o_MEM_is_take_branch, 1);
        chk("t1 redirect", o_redirect, 1);
        chk("t1 redirect_pc", o_redirect_pc, 32'h200);
        chk("t1 mispred_cnt before", o_mispred_cnt, 0);
        step(nop(32'h10c), 0);
        chk("t1 ifid squashed", dut.ifid_valid, 0);
        chk("t1 idex squashed", dut.idex_valid, 0);
        chk("t1 redirect cleared", o_redirect, 0);
        chk("t1 mispred_cnt", o_mispred_cnt, 1);
        repeat (3) step(nop(32'h200), 0);

        // correctly predicted taken branch
        do_reset("rst2");
        step(mk(32'h40, 32'h80, 1, 0, 1, 32'h80), 0);
        step(nop(32'h80), 0);
        step(nop(32'h84), 0);
        chk("t2 strobe", o_MEM_is_branch_instr, 1);
        chk("t2 take", o_MEM_is_take_branch, 1);
        chk("t2 redirect", o_redirect, 0);
        step(nop(32'h88), 0);
        chk("t2 branch_cnt", o_branch_cnt, 1);
        chk("t2 mispred_cnt", o_mispred_cnt, 0);

        // jump redirects but never trains
        do_reset("rst3");
        step(mk(32'h10, 32'h14, 0, 1, 0, 32'h300), 0);
        step(nop(32'h14), 0);
        step(nop(32'h18), 0);
        chk("t3 redirect", o_redirect, 1);
        chk("t3 redirect_pc", o_redirect_pc, 32'h300);
        chk("t3 strobe", o_MEM_is_branch_instr, 0);
        step(nop(32'h300), 0);
        chk("t3 branch_cnt", o_branch_cnt, 0);
        chk("t3 mispred_cnt", o_mispred_cnt, 1);

        // mispredict in MEM held by stall
        do_reset("rst4");
        step(mk(32'h100, 32'h104, 1, 0, 1, 32'h200), 0);
        step(nop(32'h104), 0);
        step(nop(32'h108), 0);
        chk("t4 strobe", o_MEM_is_branch_instr, 1);
        for (int i = 0; i < 4; i++) begin
            step(nop(32'h200), 1);
            chk("t4 stall strobe", o_MEM_is_branch_instr, 0);
            chk("t4 stall redirect", o_redirect, 0);
            chk("t4 stall branch_pc", o_MEM_branch_pc, 32'h100);
            chk("t4 stall branch_cnt", o_branch_cnt, 1);
            chk("t4 stall mispred_cnt", o_mispred_cnt, 1);
        end
        step(mk(32'h200, 32'h300, 1, 0, 1, 32'h300), 0);
        step(nop(32'h300), 1);
        step(nop(32'h300), 1);
        step(nop(32'h300), 0);
        step(nop(32'h304), 0);
        chk("t4b strobe", o_MEM_is_branch_instr, 1);
        chk("t4b branch_pc", o_MEM_branch_pc, 32'h200);
        chk("t4b redirect", o_redirect, 0);
        step(nop(32'h308), 0);
        chk("t4b branch_cnt", o_branch_cnt, 2);

        // back-to-back branches, younger one squashed
        do_reset("rst5");
        step(mk(32'h100, 32'h104, 1, 0, 1, 32'h200), 0);
        step(mk(32'h104, 32'h108, 1, 0, 1, 32'h500), 0);
        step(nop(32'h108), 0);
        chk("t5 first redirect", o_redirect, 1);
        step(nop(32'h10c), 0);
        chk("t5 flush edge strobe", o_MEM_is_branch_instr, 0);
        step(mk(32'h200, 32'h204, 1, 0, 0, 32'h999), 0);
        chk("t5 squashed strobe", o_MEM_is_branch_instr, 0);
        step(nop(32'h204), 0);
        chk("t5 squashed strobe2", o_MEM_is_branch_instr | o_redirect, 0);
        step(nop(32'h208), 0);
        chk("t5 next strobe", o_MEM_is_branch_instr, 1);
        chk("t5 next branch_pc", o_MEM_branch_pc, 32'h200);
        chk("t5 next take", o_MEM_is_take_branch, 0);
        chk("t5 next redirect", o_redirect, 0);
        step(nop(32'h20c), 0);
        chk("t5 branch_cnt", o_branch_cnt, 2);
        chk("t5 mispred_cnt", o_mispred_cnt, 1);

        // reset during pending redirect, then counter wrap
        step(mk(32'h100, 32'h104, 1, 0, 1, 32'h200), 0);
        step(nop(32'h104), 0);
        step(nop(32'h108), 0);
        chk("t6 pending redirect", o_redirect, 1);
        do_reset("t6 rst");
        step(BUB, 0);
        chk("t6 quiet1", {o_MEM_is_branch_instr, o_redirect}, 0);
        step(BUB, 0);
        chk("t6 quiet2", {o_MEM_is_branch_instr, o_redirect}, 0);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i) * 32'd4;
            step(mk(pc, pc + 32'd4, 1, 0, 0, 32'h2000), 0);
        end
        repeat (3) step(BUB, 0);
        chk("t6 branch_cnt", o_branch_cnt, 16);
        chk("t6 branch_cnt4 wrap", b4_branch_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
